vedic_seq_mult_ctrl: RTL
========================

Name: vedic_seq_mult_ctrl

Overview:
Sequential N x N unsigned multiplier controller. It time-shares one internal multiply_2to2 (2x2 Vedic) datapath instance over all 2-bit digit pairs of the operands. It accumulates the shifted 4-bit partial products into a 2N-bit result. Operand input and product output each use a valid/ready handshake, so the block sits between an operand source and a result consumer in the Vedic multiplier hierarchy.

Parameters:
N, 8, operand width in bits; must be even and >= 2
D, N/2, derived (localparam): number of 2-bit digits per operand

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair a/b valid
in_ready  output  1  block can accept operands
a  input  N  multiplicand, unsigned
b  input  N  multiplier, unsigned
out_valid  output  1  product p valid
out_ready  input  1  consumer accepts p
p  output  2N  product a*b, unsigned
busy  output  1  high in MUL or DONE

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (async assert, sync use after deassert): state=IDLE, in_ready=1, out_valid=0, busy=0, p=0. Internal a_r, b_r, acc, i and j are cleared to 0.
- FSM states: IDLE, MUL, DONE. Encoding is free.
- IDLE: in_ready=1.
  - On an edge with in_valid & in_ready: capture a_r=a, b_r=b; clear acc=0, i=0, j=0; go to MUL.
  - in_valid=0: stay in IDLE.
- MUL: in_ready=0, busy=1.
  - Each cycle, the 2x2 unit receives a_r[2i+1:2i] and b_r[2j+1:2j] combinationally.
  - At the edge: acc += {pp4} << 2(i+j), with the sum taken at 2N-bit width. No overflow is possible because the final acc <= (2^N-1)^2.
  - Index update: j increments. When j=D-1, j wraps to 0 and i increments.
  - When i=D-1 and j=D-1, the last partial product is accumulated and the FSM goes to DONE.
  - MUL lasts exactly D*D cycles (16 for N=8).
- DONE: out_valid=1, p=acc, busy=1, in_ready=0.
  - p is held stable while out_valid=1 and out_ready=0.
  - On an edge with out_valid & out_ready: go to IDLE, out_valid=0. p retains its value; only out_valid qualifies it.
- Latency: out_valid is first high D*D cycles after the input handshake edge.
- Throughput: one product per D*D+2 cycles with continuous valid/ready. Operands are not accepted in the DONE or MUL states.
- in_valid while busy: ignored, because in_ready=0. The source must hold a/b and in_valid until the handshake.
- Inputs a/b are sampled only at the handshake. Later changes do not affect the product in progress.
- out_ready while out_valid=0: has no effect.
- N=2: MUL lasts 1 cycle, and p equals the multiply_2to2 output for a_r and b_r.
- Reset mid-operation, in MUL or DONE: the result is aborted and the block returns immediately to the reset values. No out_valid is produced for the aborted operation.
- No X-propagation: every register has a reset value.

Test Plan:
- N=8, a=3, b=2, out_ready=1 -> out_valid rises 16 cycles after the handshake, p=16'd6; in_ready returns to 1 one cycle after the out handshake.
- N=8, a=255, b=255 -> p=16'd65025 (0xFE01). Then a=0, b=173 -> p=0. Then a=170, b=85 -> p=14450.
- Back-pressure: out_ready=0 for 5 cycles after out_valid -> out_valid and p=6 are held constant for all 5 cycles and in_ready stays 0. Handshake on the 6th cycle -> IDLE.
- A new in_valid with a=9, b=9 is asserted during MUL -> in_ready=0 and the operands are ignored. The first product completes correctly. The second pair is then accepted, with p=81 after a further 16 cycles.
- Assert rst_n=0 at MUL cycle 7 of a=200, b=100 -> out_valid=0, p=0 and in_ready=1 immediately, with no spurious output. A new op with a=12, b=11 then gives p=132.
- Random regression: 1000 random pairs for each of N=2, 4, 8, with random in_valid/out_ready gaps -> every p equals a*b. For N=2 the latency is 1 cycle.

Source files
------------

// File: rtl/vedic_seq_mult_ctrl.sv
// Sequential N x N unsigned multiplier that reuses one 2x2 Vedic cell over every
// digit pair. Shifted partial products are accumulated into a 2N-bit product.

module multiply_2to2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic x, y, c1, t;

  // Vertical and crosswise terms, combined with two half adders
  assign x    = a[1] & b[0];
  assign y    = a[0] & b[1];
  assign t    = a[1] & b[1];
  assign c1   = x & y;
  assign p[0] = a[0] & b[0];
  assign p[1] = x ^ y;
  assign p[2] = t ^ c1;
  assign p[3] = t & c1;
endmodule

module vedic_seq_mult_ctrl #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p,
  output logic           busy
);
  localparam int D  = N / 2;
  localparam int IW = (D > 1) ? $clog2(D) : 1;
  localparam int W  = 2 * N;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t         state;
  logic [N-1:0]   a_r, b_r;
  logic [W-1:0]   acc;
  logic [IW-1:0]  i, j;

  logic [1:0]     da, db;
  logic [3:0]     pp;
  logic [IW+1:0]  shamt;
  logic [W-1:0]   pp_sh, acc_nxt;
  logic           last, j_wrap;

  generate
    if (D == 1) begin : g_one_digit
      assign da     = a_r[1:0];
      assign db     = b_r[1:0];
      assign shamt  = '0;
      assign last   = 1'b1;
      assign j_wrap = 1'b1;
    end else begin : g_multi_digit
      logic [D-1:0][1:0] a_dig, b_dig;
      assign a_dig  = a_r;
      assign b_dig  = b_r;
      assign da     = a_dig[i];
      assign db     = b_dig[j];
      // digit weight is 4^(i+j), i.e. a shift of 2(i+j)
      assign shamt  = {({1'b0, i} + {1'b0, j}), 1'b0};
      assign j_wrap = (j == IW'(D - 1));
      assign last   = (i == IW'(D - 1)) && j_wrap;
    end
  endgenerate

  multiply_2to2 u_m2 (
    .a (da),
    .b (db),
    .p (pp)
  );

  assign pp_sh   = W'(pp) << shamt;
  assign acc_nxt = acc + pp_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      acc       <= '0;
      i         <= '0;
      j         <= '0;
      p         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_r      <= a;
            b_r      <= b;
            acc      <= '0;
            i        <= '0;
            j        <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= MUL;
          end
        end
        MUL: begin
          acc <= acc_nxt;
          if (last) begin
            p         <= acc_nxt;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (j_wrap) begin
            j <= '0;
            i <= i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
        end
        DONE: begin
          // p stays put after the handshake; out_valid alone qualifies it
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
